speed_cmp_bank: RTL and testbench

SPEED_CMP_BANK -- requirements
Module: speed_cmp_bank

---
 rtl/speed_cmp_bank_if.sv | 27 ++
 rtl/speed_cmp_bank.sv | 125 ++++++++++++
 tb/tb_speed_cmp_bank.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/speed_cmp_bank_if.sv
// Sample/compare bus for speed_cmp_bank: strobed measurement inputs and
// per-channel region and sticky flags.
interface speed_cmp_bank_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2
);
    logic                 en;
    logic [NCH*WIDTH-1:0] meas;
    logic [NCH*WIDTH-1:0] target;
    logic [NCH-1:0]       clr;
    logic [NCH-1:0]       below;
    logic [NCH-1:0]       inwin;
    logic [NCH-1:0]       above;
    logic [NCH-1:0]       sticky_below;
    logic [NCH-1:0]       sticky_above;
    logic                 irq;

    modport master (
        output en, meas, target, clr,
        input  below, inwin, above, sticky_below, sticky_above, irq
    );

    modport slave (
        input  en, meas, target, clr,
        output below, inwin, above, sticky_below, sticky_above, irq
    );
endinterface

// File: rtl/speed_cmp_bank.sv
// Bank of NCH debounced window comparators: each channel classifies meas
// against target +/- TOL and commits a region after DEB matching samples.
module speed_cmp_bank #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int TOL   = 2,
    parameter int DEB   = 3
) (
    input  logic            clk,
    input  logic            reset,
    speed_cmp_bank_if.slave bus
);
    typedef enum logic [1:0] {
        ST_UNKNOWN,
        ST_BELOW,
        ST_INWIN,
        ST_ABOVE
    } state_t;

    localparam logic [WIDTH:0] TOL_W = (WIDTH+1)'(TOL);
    localparam logic [3:0]     DEB_C = 4'(DEB);

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    state_t         cand_q  [NCH];
    state_t         cand_d  [NCH];
    state_t         raw     [NCH];
    logic [3:0]     cnt_q   [NCH];
    logic [3:0]     cnt_d   [NCH];
    logic [3:0]     cnt_inc [NCH];
    logic [WIDTH:0] meas_x  [NCH];
    logic [WIDTH:0] tgt_x   [NCH];

    logic [NCH-1:0] below_q;
    logic [NCH-1:0] inwin_q;
    logic [NCH-1:0] above_q;
    logic [NCH-1:0] sticky_below_q;
    logic [NCH-1:0] sticky_below_d;
    logic [NCH-1:0] sticky_above_q;
    logic [NCH-1:0] sticky_above_d;
    logic           irq_q;

    // One extra bit on both sides keeps meas+TOL and target+TOL from wrapping.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            meas_x[i] = {1'b0, bus.meas[i*WIDTH +: WIDTH]};
            tgt_x[i]  = {1'b0, bus.target[i*WIDTH +: WIDTH]};
            if (meas_x[i] + TOL_W < tgt_x[i]) begin
                raw[i] = ST_BELOW;
            end else if (meas_x[i] > tgt_x[i] + TOL_W) begin
                raw[i] = ST_ABOVE;
            end else begin
                raw[i] = ST_INWIN;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cand_d[i]  = cand_q[i];
            cnt_d[i]   = cnt_q[i];
            cnt_inc[i] = '0;
            if (bus.en) begin
                if (raw[i] == state_q[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    if (raw[i] == cand_q[i] && cnt_q[i] != '0) begin
                        cnt_inc[i] = cnt_q[i] + 4'd1;
                    end else begin
                        cand_d[i]  = raw[i];
                        cnt_inc[i] = 4'd1;
                    end
                    if (cnt_inc[i] == DEB_C) begin
                        state_d[i] = raw[i];
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_inc[i];
                    end
                end
            end
            // An entry on the same edge as clr keeps the flag set.
            sticky_below_d[i] = (state_d[i] == ST_BELOW && state_q[i] != ST_BELOW)
                                || (sticky_below_q[i] && !bus.clr[i]);
            sticky_above_d[i] = (state_d[i] == ST_ABOVE && state_q[i] != ST_ABOVE)
                                || (sticky_above_q[i] && !bus.clr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= ST_UNKNOWN;
                cand_q[i]  <= ST_INWIN;
                cnt_q[i]   <= '0;
            end
            below_q        <= '0;
            inwin_q        <= '0;
            above_q        <= '0;
            sticky_below_q <= '0;
            sticky_above_q <= '0;
            irq_q          <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cand_q[i]  <= cand_d[i];
                cnt_q[i]   <= cnt_d[i];
                below_q[i] <= (state_d[i] == ST_BELOW);
                inwin_q[i] <= (state_d[i] == ST_INWIN);
                above_q[i] <= (state_d[i] == ST_ABOVE);
            end
            sticky_below_q <= sticky_below_d;
            sticky_above_q <= sticky_above_d;
            irq_q          <= (|sticky_below_d) || (|sticky_above_d);
        end
    end

    assign bus.below        = below_q;
    assign bus.inwin        = inwin_q;
    assign bus.above        = above_q;
    assign bus.sticky_below = sticky_below_q;
    assign bus.sticky_above = sticky_above_q;
    assign bus.irq          = irq_q;

endmodule

// File: tb/tb_speed_cmp_bank.sv
// Bench for speed_cmp_bank: a default bank (A) and a DEB=1, 4-channel, 12-bit
// bank (B), checked every cycle against a history-based model plus literals.
module tb_speed_cmp_bank;
    localparam int R_UNK = 0;
    localparam int R_BEL = 1;
    localparam int R_IN  = 2;
    localparam int R_ABV = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    speed_cmp_bank_if #(.WIDTH(8),  .NCH(2)) ifa ();
    speed_cmp_bank_if #(.WIDTH(12), .NCH(4)) ifb ();

    speed_cmp_bank #(.WIDTH(8), .NCH(2), .TOL(2), .DEB(3)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    speed_cmp_bank #(.WIDTH(12), .NCH(4), .TOL(2), .DEB(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: committed region, raw samples since the last in-state sample, sticky flags.
    int mst   [2][4];
    int hist  [2][4][$];
    bit m_stb [2][4];
    bit m_sta [2][4];
    bit started = 1'b0;
    bit tog     = 1'b0;

    function automatic int region(input int m, input int t, input int tol);
        if (m + tol < t) return R_BEL;
        if (m > t + tol) return R_ABV;
        return R_IN;
    endfunction

    task automatic model_ch(input int d, input int c, input int deb, input bit rst,
                            input bit en, input int r, input bit cl);
        int entered;
        bit same;
        entered = R_UNK;
        if (rst) begin
            mst[d][c] = R_UNK;
            hist[d][c].delete();
            m_stb[d][c] = 1'b0;
            m_sta[d][c] = 1'b0;
            return;
        end
        if (en) begin
            if (r == mst[d][c]) begin
                hist[d][c].delete();
            end else begin
                hist[d][c].push_back(r);
                if (hist[d][c].size() >= deb) begin
                    same = 1'b1;
                    for (int k = 0; k < deb; k++)
                        if (hist[d][c][hist[d][c].size() - 1 - k] != r) same = 1'b0;
                    if (same) begin
                        mst[d][c] = r;
                        entered   = r;
                        hist[d][c].delete();
                    end
                end
            end
        end
        m_stb[d][c] = (entered == R_BEL) || (m_stb[d][c] && !cl);
        m_sta[d][c] = (entered == R_ABV) || (m_sta[d][c] && !cl);
    endtask

    function automatic logic [31:0] expv(input int d, input int n, input int kind);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < n; c++) begin
            case (kind)
                1:       v[c] = (mst[d][c] == R_BEL);
                2:       v[c] = (mst[d][c] == R_IN);
                3:       v[c] = (mst[d][c] == R_ABV);
                4:       v[c] = m_stb[d][c];
                default: v[c] = m_sta[d][c];
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++)
            model_ch(0, c, 3, reset, ifa.en,
                     region(int'(ifa.meas[c*8 +: 8]), int'(ifa.target[c*8 +: 8]), 2),
                     ifa.clr[c]);
        for (int c = 0; c < 4; c++)
            model_ch(1, c, 1, reset, ifb.en,
                     region(int'(ifb.meas[c*12 +: 12]), int'(ifb.target[c*12 +: 12]), 2),
                     ifb.clr[c]);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("A.below",  {30'b0, ifa.below},        expv(0, 2, 1));
            chk("A.inwin",  {30'b0, ifa.inwin},        expv(0, 2, 2));
            chk("A.above",  {30'b0, ifa.above},        expv(0, 2, 3));
            chk("A.stk_b",  {30'b0, ifa.sticky_below}, expv(0, 2, 4));
            chk("A.stk_a",  {30'b0, ifa.sticky_above}, expv(0, 2, 5));
            chk("A.irq",    {31'b0, ifa.irq},          {31'b0, |(expv(0, 2, 4) | expv(0, 2, 5))});
            chk("B.below",  {28'b0, ifb.below},        expv(1, 4, 1));
            chk("B.inwin",  {28'b0, ifb.inwin},        expv(1, 4, 2));
            chk("B.above",  {28'b0, ifb.above},        expv(1, 4, 3));
            chk("B.stk_b",  {28'b0, ifb.sticky_below}, expv(1, 4, 4));
            chk("B.stk_a",  {28'b0, ifb.sticky_above}, expv(1, 4, 5));
            chk("B.irq",    {31'b0, ifb.irq},          {31'b0, |(expv(1, 4, 4) | expv(1, 4, 5))});
        end
    end

    // Channel 1 of bank A alternates INWIN/ABOVE on every en sample so it never commits.
    task automatic samp_a(input bit e, input int m0, input int t0, input logic [1:0] cl);
        @(negedge clk);
        ifa.en           = e;
        ifa.meas[7:0]    = 8'(m0);
        ifa.target[7:0]  = 8'(t0);
        ifa.meas[15:8]   = tog ? 8'd30 : 8'd20;
        ifa.target[15:8] = 8'd20;
        ifa.clr          = cl;
        if (e) tog = ~tog;
        @(posedge clk);
        #1;
    endtask

    task automatic samp_b(input bit e, input logic [47:0] m, input logic [47:0] t);
        @(negedge clk);
        ifb.en     = e;
        ifb.meas   = m;
        ifb.target = t;
        ifb.clr    = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_zero(input string name);
        chk({name, ".state"}, {26'b0, ifa.below, ifa.inwin, ifa.above}, 32'h0);
        chk({name, ".stk"},   {28'b0, ifa.sticky_below, ifa.sticky_above}, 32'h0);
        chk({name, ".irq"},   {31'b0, ifa.irq}, 32'h0);
    endtask

    int bm [6] = '{18, 22, 17, 23, 0, 255};
    int bt [6] = '{20, 20, 20, 20, 1, 254};
    int bx [6] = '{2, 2, 1, 4, 2, 2};
    int pat[6] = '{30, 30, 20, 30, 30, 30};
    int pex[6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        reset      = 1'b1;
        ifa.en     = 1'b1;
        ifa.meas   = {8'd20, 8'd10};
        ifa.target = {8'd20, 8'd20};
        ifa.clr    = 2'b11;
        ifb.en     = 1'b1;
        ifb.meas   = '0;
        ifb.target = '0;
        ifb.clr    = '1;

        // Reset overrides en and clr.
        repeat (2) @(posedge clk);
        #1;
        chk_a_zero("rst");
        chk("rst.B", {20'b0, ifb.below, ifb.inwin, ifb.above}, 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        ifa.en = 1'b0;
        ifa.clr = '0;
        ifb.en = 1'b0;
        ifb.clr = '0;

        // Channel 0 below target: commits on the third en edge.
        samp_a(1'b1, 10, 20, 2'b00);
        chk("deb1.below", {31'b0, ifa.below[0]}, 32'h0);
        samp_a(1'b1, 10, 20, 2'b00);
        chk("deb2.below", {31'b0, ifa.below[0]}, 32'h0);
        samp_a(1'b1, 10, 20, 2'b00);
        chk("deb3.below", {31'b0, ifa.below[0]}, 32'h1);
        chk("deb3.stk_b", {31'b0, ifa.sticky_below[0]}, 32'h1);
        chk("deb3.irq",   {31'b0, ifa.irq}, 32'h1);
        chk("deb3.ch1",   {29'b0, ifa.below[1], ifa.inwin[1], ifa.above[1]}, 32'h0);

        // Window boundaries, including the wrap-prone extremes.
        for (int k = 0; k < 6; k++) begin
            repeat (3) samp_a(1'b1, bm[k], bt[k], 2'b00);
            chk($sformatf("bnd%0d", k), {29'b0, ifa.above[0], ifa.inwin[0], ifa.below[0]}, 32'(bx[k]));
        end

        samp_a(1'b0, 255, 254, 2'b11);
        chk("clr.stk", {28'b0, ifa.sticky_below, ifa.sticky_above}, 32'h0);
        chk("clr.irq", {31'b0, ifa.irq}, 32'h0);

        // Broken run toward ABOVE, with en=0 gaps carrying junk values.
        for (int k = 0; k < 6; k++) begin
            samp_a(1'b1, pat[k], 20, 2'b00);
            chk($sformatf("brk%0d", k), {31'b0, ifa.above[0]}, 32'(pex[k]));
            samp_a(1'b0, 0, 20, 2'b00);
        end
        chk("brk.stk", {30'b0, ifa.sticky_below[0], ifa.sticky_above[0]}, 32'h1);

        // Clear on the entry edge: set wins for BELOW, ABOVE flag cleared.
        samp_a(1'b1, 10, 20, 2'b00);
        samp_a(1'b1, 10, 20, 2'b00);
        samp_a(1'b1, 10, 20, 2'b01);
        chk("cp.below", {31'b0, ifa.below[0]}, 32'h1);
        chk("cp.stk",   {30'b0, ifa.sticky_below[0], ifa.sticky_above[0]}, 32'h2);
        chk("cp.irq",   {31'b0, ifa.irq}, 32'h1);
        samp_a(1'b1, 10, 20, 2'b01);
        chk("cp2.stk",  {30'b0, ifa.sticky_below[0], ifa.sticky_above[0]}, 32'h0);
        chk("cp2.irq",  {31'b0, ifa.irq}, 32'h0);

        // Reset aborts a debounce two samples into ABOVE.
        samp_a(1'b1, 30, 20, 2'b00);
        samp_a(1'b1, 30, 20, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_a_zero("rmid");
        @(negedge clk);
        reset  = 1'b0;
        ifa.en = 1'b0;
        samp_a(1'b1, 30, 20, 2'b00);
        chk("rmid1.above", {31'b0, ifa.above[0]}, 32'h0);
        samp_a(1'b1, 30, 20, 2'b00);
        chk("rmid2.above", {31'b0, ifa.above[0]}, 32'h0);
        samp_a(1'b1, 30, 20, 2'b00);
        chk("rmid3.above", {31'b0, ifa.above[0]}, 32'h1);

        // Bank B (DEB=1): every channel commits on its first sample.
        samp_b(1'b1, {12'd4095, 12'd900, 12'd500, 12'd100}, {12'd4094, 12'd100, 12'd500, 12'd200});
        chk("B1", {20'b0, ifb.below, ifb.inwin, ifb.above}, {20'b0, 4'b0001, 4'b1010, 4'b0100});
        chk("B1.stk", {24'b0, ifb.sticky_below, ifb.sticky_above}, {24'b0, 4'b0001, 4'b0100});
        samp_b(1'b1, {12'd4095, 12'd900, 12'd600, 12'd100}, {12'd4094, 12'd100, 12'd500, 12'd200});
        chk("B2", {20'b0, ifb.below, ifb.inwin, ifb.above}, {20'b0, 4'b0001, 4'b1000, 4'b0110});
        samp_b(1'b1, {12'd4095, 12'd0, 12'd600, 12'd100}, {12'd4094, 12'd100, 12'd500, 12'd200});
        chk("B3", {20'b0, ifb.below, ifb.inwin, ifb.above}, {20'b0, 4'b0101, 4'b1000, 4'b0010});
        samp_b(1'b1, {12'd0, 12'd0, 12'd600, 12'd100}, {12'd4094, 12'd100, 12'd500, 12'd200});
        chk("B4", {20'b0, ifb.below, ifb.inwin, ifb.above}, {20'b0, 4'b1101, 4'b0000, 4'b0010});
        samp_b(1'b0, {12'd4095, 12'd4095, 12'd0, 12'd4095}, {12'd0, 12'd0, 12'd4095, 12'd0});
        chk("B5", {20'b0, ifb.below, ifb.inwin, ifb.above}, {20'b0, 4'b1101, 4'b0000, 4'b0010});
        samp_b(1'b1, {12'd0, 12'd0, 12'd600, 12'd200}, {12'd4094, 12'd100, 12'd500, 12'd200});
        chk("B6", {20'b0, ifb.below, ifb.inwin, ifb.above}, {20'b0, 4'b1100, 4'b0001, 4'b0010});

        samp_b(1'b0, {12'd0, 12'd0, 12'd600, 12'd200}, {12'd4094, 12'd100, 12'd500, 12'd200});
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
